pla_cfg_loader: RTL

- Configuration loader for the PLA OR plane.
- Accepts a serial programming bitstream and assembles one NUM_INPUTS-wide select word per OR-plane cell.
- Drives each word onto the shared sel bus, then issues a clean, registered one-cycle wen strobe to that cell. The cell latches sel on the wen rising edge.
- Sits directly upstream of the OR-plane cells; one loader serves NUM_TERMS cells.

---
 rtl/pla_cfg_loader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pla_cfg_loader.sv
// Serial configuration loader for the PLA OR plane: assembles select words and strobes them into the cells.
// Optional even-parity checking per word is enabled with `define PLA_CFG_PARITY_EN.
module pla_cfg_loader #(
  parameter int NUM_INPUTS = 5,
  parameter int NUM_TERMS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic                  bit_ready,
  output logic [NUM_INPUTS-1:0] sel,
  output logic [NUM_TERMS-1:0]  wen,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
`ifdef PLA_CFG_PARITY_EN
  localparam int LAST_BIT = NUM_INPUTS;
`else
  localparam int LAST_BIT = NUM_INPUTS - 1;
`endif
  localparam int CNT_W  = $clog2(NUM_INPUTS + 1);
  localparam int TERM_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_SETUP, S_STROBE, S_HOLD, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [TERM_W-1:0]     term_q, term_d;
  logic [NUM_INPUTS-1:0] word_q, word_d;
  logic [NUM_INPUTS-1:0] sel_q, sel_d;
  logic [NUM_TERMS-1:0]  wen_q, wen_d;
  logic                  ready_q, busy_q, done_q;
  logic                  accept;
  logic                  skip_wen;
`ifdef PLA_CFG_PARITY_EN
  logic                  bad_q, bad_d;
  logic                  err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    term_d    = term_q;
    word_d    = word_q;
    sel_d     = sel_q;
    skip_wen  = 1'b0;
`ifdef PLA_CFG_PARITY_EN
    bad_d     = bad_q;
    err_d     = err_q;
`endif
    accept    = bit_valid && ready_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SHIFT;
          term_d    = '0;
          bit_cnt_d = '0;
`ifdef PLA_CFG_PARITY_EN
          err_d     = 1'b0;
`endif
        end
      end
      S_SHIFT: begin
        if (accept) begin
          if (bit_cnt_q < CNT_W'(NUM_INPUTS)) word_d[bit_cnt_q] = bit_in;
          if (bit_cnt_q == CNT_W'(LAST_BIT)) begin
            // sel is loaded on entry to SETUP so it is stable a full cycle before wen rises
            state_d = S_SETUP;
            sel_d   = word_d;
`ifdef PLA_CFG_PARITY_EN
            bad_d   = (^word_q) != bit_in;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
`ifdef PLA_CFG_PARITY_EN
        skip_wen = bad_q;
        err_d    = err_q | bad_q;
`endif
      end
      S_STROBE: state_d = S_HOLD;
      S_HOLD: begin
        if (term_q == TERM_W'(NUM_TERMS - 1)) begin
          state_d = S_DONE;
        end else begin
          term_d    = term_q + 1'b1;
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobe is decoded from the next state so wen comes straight from a flop
    wen_d = '0;
    if (state_d == S_STROBE && !skip_wen) wen_d[term_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      term_q    <= '0;
      word_q    <= '0;
      sel_q     <= '0;
      wen_q     <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PLA_CFG_PARITY_EN
      bad_q     <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      term_q    <= term_d;
      word_q    <= word_d;
      sel_q     <= sel_d;
      wen_q     <= wen_d;
      ready_q   <= (state_d == S_SHIFT);
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
`ifdef PLA_CFG_PARITY_EN
      bad_q     <= bad_d;
      err_q     <= err_d;
`endif
    end
  end

  assign bit_ready = ready_q;
  assign sel       = sel_q;
  assign wen       = wen_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef PLA_CFG_PARITY_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule
